conv_mul_share_arb: RTL

//   Shares one unsigned 8x14 DSP48 multiplier among NUM_REQ requesters in the conv core.

---
 rtl/conv_mul_share_arb.sv | 122 ++++++++++++
 1 files changed

// File: rtl/conv_mul_share_arb.sv
// Round-robin arbiter that shares one unsigned A_W x B_W multiplier among NUM_REQ requesters.
// The pipeline is NUM_STAGE deep and each result is tagged with its requester. `CONV_MUL_PERF_EN adds the busy_cnt accept counter.
module conv_mul_share_arb #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_STAGE = 3,
    parameter int A_W       = 8,
    parameter int B_W       = 14,
    parameter int P_W       = 22,
    parameter int ID_W      = 2
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [P_W-1:0]         res_p
`ifdef CONV_MUL_PERF_EN
    ,
    output logic [31:0]            busy_cnt
`endif
);

    logic [ID_W-1:0]      ptr;
    logic [NUM_STAGE-1:0] stg_vld;
    logic [ID_W-1:0]      stg_id [NUM_STAGE];
    logic [P_W-1:0]       stg_p  [NUM_STAGE];
    logic [NUM_STAGE-1:0] ld;

    logic                 found;
    logic                 accept;
    logic [ID_W-1:0]      grant_idx;
    logic [ID_W:0]        cand;
    logic [ID_W-1:0]      cand_idx;
    logic [A_W-1:0]       a_sel;
    logic [B_W-1:0]       b_sel;
    logic [P_W-1:0]       prod;
    logic [ID_W-1:0]      next_ptr;

    // Stage k may load when some stage at or after k is empty or the output drains;
    // this squeezes bubbles out even while the result at the output is being held.
    genvar k;
    generate
        for (k = 0; k < NUM_STAGE; k++) begin : g_ld
            assign ld[k] = res_ready | ~(&stg_vld[NUM_STAGE-1:k]);
        end
    endgenerate

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        cand_idx  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(off);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            cand_idx = cand[ID_W-1:0];
            if (!found && req_valid[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign accept    = found & ld[0];
    assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    assign a_sel     = req_a[int'(grant_idx)*A_W +: A_W];
    assign b_sel     = req_b[int'(grant_idx)*B_W +: B_W];
    assign prod      = P_W'(a_sel) * P_W'(b_sel);
    assign next_ptr  = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ptr     <= '0;
            stg_vld <= '0;
            for (int s = 0; s < NUM_STAGE; s++) begin
                stg_id[s] <= '0;
                stg_p[s]  <= '0;
            end
        end else begin
            if (accept) begin
                ptr <= next_ptr;
            end
            if (ld[0]) begin
                stg_vld[0] <= accept;
                if (accept) begin
                    stg_id[0] <= grant_idx;
                    stg_p[0]  <= prod;
                end
            end
            for (int s = 1; s < NUM_STAGE; s++) begin
                if (ld[s]) begin
                    stg_vld[s] <= stg_vld[s-1];
                    if (stg_vld[s-1]) begin
                        stg_id[s] <= stg_id[s-1];
                        stg_p[s]  <= stg_p[s-1];
                    end
                end
            end
        end
    end

    assign res_valid = stg_vld[NUM_STAGE-1];
    assign res_id    = stg_id[NUM_STAGE-1];
    assign res_p     = stg_p[NUM_STAGE-1];

`ifdef CONV_MUL_PERF_EN
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            busy_cnt <= '0;
        end else if (accept) begin
            busy_cnt <= busy_cnt + 32'd1;
        end
    end
`endif

endmodule
